// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-in / byte-out bundle between the UART receiver and the
// downstream operand/opcode loader.
//   rx               serial line, idle high (into the receiver)
//   rx_done_tick     one-clk pulse, a good frame was received
//   rx_data          last good byte received
//   frame_error_tick one-clk pulse, stop bit sampled low
// master: the receiver side; slave: the consumer / line driver side.
interface uart_rx_if #(
  parameter int NBIT_DATA_LEN = 8
);
  logic                     rx;
  logic                     rx_done_tick;
  logic [NBIT_DATA_LEN-1:0] rx_data;
  logic                     frame_error_tick;

  modport master (
    input  rx,
    output rx_done_tick,
    output rx_data,
    output frame_error_tick
  );

  modport slave (
    output rx,
    input  rx_done_tick,
    input  rx_data,
    input  frame_error_tick
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with 16x oversampling from an internal
// baud-tick divider. Each good frame updates rx_data and pulses rx_done_tick
// for one clk; a low stop bit pulses frame_error_tick and then the receiver
// waits for the line to return high before re-arming.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if master modport (rx in; rx_done_tick, rx_data,
//          frame_error_tick out)
module uart_rx #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SB_TICKS      = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = ($clog2(SB_TICKS) > 4) ? $clog2(SB_TICKS) : 4;
  localparam int NW = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] MID_START = SW'(7);
  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(NBIT_DATA_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                   state;
  logic                     rx_meta;
  logic                     rx_s;
  logic [TW-1:0]            tick_cnt;
  logic                     s_tick;
  logic [SW-1:0]            s_cnt;
  logic [NW-1:0]            n_cnt;
  logic [NBIT_DATA_LEN-1:0] shreg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running divider, never resynced to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign s_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      s_cnt                <= '0;
      n_cnt                <= '0;
      shreg                <= '0;
      bus.rx_data          <= '0;
      bus.rx_done_tick     <= 1'b0;
      bus.frame_error_tick <= 1'b0;
    end else begin
      bus.rx_done_tick     <= 1'b0;
      bus.frame_error_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_cnt == MID_START) begin
              if (!rx_s) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                // Line back high at mid start bit: treat as a glitch.
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_cnt == BIT_LAST) begin
              shreg <= {rx_s, shreg[NBIT_DATA_LEN-1:1]};
              s_cnt <= '0;
              if (n_cnt == N_LAST) begin
                state <= STOP;
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_cnt == STOP_LAST) begin
              if (rx_s) begin
                bus.rx_data      <= shreg;
                bus.rx_done_tick <= 1'b1;
                state            <= IDLE;
              end else begin
                bus.frame_error_tick <= 1'b1;
                state                <= WAIT_HIGH;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be read as further start bits.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
